// File: rtl/uncache_data_responder_pkg.sv
// Shared types for the uncached data path between the MEM stage and the bus bridge.
package uncache_data_responder_pkg;

    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;
    localparam int REQ_STRB_W = REQ_DATA_W / 8;

    // Access size encodings carried on req_size / rd_size / wr_size.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Encoding is visible on the dbg_state port, so IDLE is pinned to zero.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_RESP    = 3'd5,
        ST_DRAIN   = 3'd6
    } uncache_state_e;

    // One data request as seen on the LSU port.
    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [1:0]            size;
        logic [REQ_STRB_W-1:0] wstrb;
        logic [REQ_DATA_W-1:0] wdata;
    } dreq_t;

endpackage

// File: rtl/uncache_data_responder.sv
// Uncached data responder: takes one load/store from the LSU port, runs it on an
// SRAM-like read/write bus and returns a one-cycle data_ok. A flush after the
// bus has accepted the transfer lets it finish (DRAIN) but suppresses the reply.
//
// Handshakes: a bus request transfers on the cycle where rd_req&rd_rdy (or
// wr_req&wr_rdy) are both high at the clock edge; rd_req/wr_req and their fields
// stay stable until then. ret_valid / wr_done are single-cycle completion strobes
// that are only consumed in RD_WAIT/WR_WAIT/DRAIN. On the LSU side req_valid is
// held by the requester until data_ok and is only sampled in IDLE.
module uncache_data_responder
    import uncache_data_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  flush,
    output logic                  data_ok,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  cache_miss,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [1:0]            rd_size,
    input  logic                  rd_rdy,
    input  logic                  ret_valid,
    input  logic [DATA_WIDTH-1:0] ret_data,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [1:0]            wr_size,
    output logic [STRB_WIDTH-1:0] wr_wstrb,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_rdy,
    input  logic                  wr_done,
    output logic [2:0]            dbg_state
);

    uncache_state_e        state_q, state_d;
    logic                  data_ok_q, data_ok_d;
    logic                  cache_miss_q, cache_miss_d;
    logic                  rd_req_q, rd_req_d;
    logic                  wr_req_q, wr_req_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // Next-state and next-output logic for the transfer FSM and request register.
    always_comb begin
        state_d      = state_q;
        data_ok_d    = 1'b0;
        cache_miss_d = cache_miss_q;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        rdata_d      = rdata_q;
        we_d         = we_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;

        case (state_q)
            ST_IDLE: begin
                cache_miss_d = 1'b0;
                if (req_valid && !flush) begin
                    we_d         = req_we;
                    addr_d       = req_addr;
                    size_d       = req_size;
                    wstrb_d      = req_wstrb;
                    wdata_d      = req_wdata;
                    cache_miss_d = 1'b1;
                    if (req_we) begin
                        state_d  = ST_WR_REQ;
                        wr_req_d = 1'b1;
                    end else begin
                        state_d  = ST_RD_REQ;
                        rd_req_d = 1'b1;
                    end
                end
            end

            ST_RD_REQ: begin
                // Once the bus has taken the read it must be allowed to finish.
                if (rd_rdy) begin
                    rd_req_d = 1'b0;
                    state_d  = flush ? ST_DRAIN : ST_RD_WAIT;
                end else if (flush) begin
                    rd_req_d     = 1'b0;
                    cache_miss_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end

            ST_RD_WAIT: begin
                if (ret_valid) begin
                    cache_miss_d = 1'b0;
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        rdata_d   = ret_data;
                        data_ok_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_WR_REQ: begin
                if (wr_rdy) begin
                    wr_req_d = 1'b0;
                    state_d  = flush ? ST_DRAIN : ST_WR_WAIT;
                end else if (flush) begin
                    wr_req_d     = 1'b0;
                    cache_miss_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end

            ST_WR_WAIT: begin
                if (wr_done) begin
                    cache_miss_d = 1'b0;
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        data_ok_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_RESP: begin
                // data_ok is high during this cycle; new requests wait for IDLE.
                cache_miss_d = 1'b0;
                state_d      = ST_IDLE;
            end

            ST_DRAIN: begin
                // Swallow the completion of a killed transfer without replying.
                if (we_q ? wr_done : ret_valid) begin
                    cache_miss_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                cache_miss_d = 1'b0;
                rd_req_d     = 1'b0;
                wr_req_d     = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; active-low synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            data_ok_q    <= 1'b0;
            cache_miss_q <= 1'b0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            rdata_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            data_ok_q    <= data_ok_d;
            cache_miss_q <= cache_miss_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            rdata_q      <= rdata_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
        end
    end

    assign data_ok    = data_ok_q;
    assign rdata      = rdata_q;
    assign cache_miss = cache_miss_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = addr_q;
    assign rd_size    = size_q;
    assign wr_req     = wr_req_q;
    assign wr_addr    = addr_q;
    assign wr_size    = size_q;
    assign wr_wstrb   = wstrb_q;
    assign wr_data    = wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uncache_data_responder.sv
// Directed bench for uncache_data_responder: a table of zero-wait transactions
// plus hand-written sequences for bus stalls, flushes, held requests and reset.
module tb_uncache_data_responder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_we, flush;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [3:0]  req_wstrb;
    logic        data_ok, cache_miss, rd_req, wr_req;
    logic [31:0] rdata, rd_addr, wr_addr, wr_data;
    logic [1:0]  rd_size, wr_size;
    logic [3:0]  wr_wstrb;
    logic        rd_rdy, ret_valid, wr_rdy, wr_done;
    logic [31:0] ret_data;
    logic [2:0]  dbg_state;

    uncache_data_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_size(req_size), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .flush(flush),
        .data_ok(data_ok), .rdata(rdata), .cache_miss(cache_miss),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size),
        .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All driving and sampling happens at the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // rd_req and wr_req must never be high together.
    always @(negedge clk) begin
        if (rst) chk("rd_wr_mutex", {63'd0, rd_req & wr_req}, 64'd0);
    end

    // ---------------- driver ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] ret_data;
        logic [31:0] exp_rdata;
    } vec_t;

    // Zero-wait transaction: accept at c0, bus request c1, completion c2, data_ok c3.
    task automatic do_txn(input vec_t v);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size;
        req_wstrb = v.wstrb; req_wdata = v.wdata; flush = 1'b0;
        cyc();  // c1
        chk("c1_cache_miss", {63'd0, cache_miss}, 64'd1);
        chk("c1_data_ok", {63'd0, data_ok}, 64'd0);
        if (!v.we) begin
            chk("c1_rd_req", {62'd0, rd_req, wr_req}, 64'b10);
            chk("c1_rd_addr", {32'd0, rd_addr}, {32'd0, v.addr});
            chk("c1_rd_size", {62'd0, rd_size}, {62'd0, v.size});
            rd_rdy = 1'b1;
        end else begin
            chk("c1_wr_req", {62'd0, rd_req, wr_req}, 64'b01);
            chk("c1_wr_addr", {32'd0, wr_addr}, {32'd0, v.addr});
            chk("c1_wr_fields", {26'd0, wr_size, wr_wstrb, wr_data},
                {26'd0, v.size, v.wstrb, v.wdata});
            wr_rdy = 1'b1;
        end
        cyc();  // c2
        rd_rdy = 1'b0; wr_rdy = 1'b0;
        chk("c2_req_drop", {62'd0, rd_req, wr_req}, 64'd0);
        chk("c2_cache_miss", {63'd0, cache_miss}, 64'd1);
        if (!v.we) begin
            ret_valid = 1'b1; ret_data = v.ret_data;
        end else begin
            wr_done = 1'b1;
        end
        exp_q.push_back(v.exp_rdata);
        cyc();  // c3
        ret_valid = 1'b0; wr_done = 1'b0; req_valid = 1'b0;
        chk("c3_data_ok", {63'd0, data_ok}, 64'd1);
        chk("c3_cache_miss", {63'd0, cache_miss}, 64'd0);
        chk("c3_rdata", {32'd0, rdata}, {32'd0, exp_q.pop_front()});
        cyc();  // c4
        chk("c4_data_ok_pulse", {63'd0, data_ok}, 64'd0);
        chk("c4_idle", {61'd0, dbg_state}, 64'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int pulses;
        int first_ok;
        vec_t v;

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_wstrb = '0; req_wdata = '0; flush = 1'b0; rd_rdy = 1'b0;
        ret_valid = 1'b0; ret_data = '0; wr_rdy = 1'b0; wr_done = 1'b0;

        // we, addr, size, wstrb, wdata, ret_data, expected rdata at data_ok
        vecs[0] = '{1'b0, 32'hBFD0_0004, 2'd2, 4'h0, 32'h0,          32'h1234_5678, 32'h1234_5678};
        vecs[1] = '{1'b1, 32'hBFD0_0003, 2'd0, 4'h8, 32'hAB00_0000, 32'h0,         32'h1234_5678};
        vecs[2] = '{1'b0, 32'h1C00_0002, 2'd1, 4'h0, 32'h0,          32'hCAFE_0000, 32'hCAFE_0000};
        vecs[3] = '{1'b1, 32'h0000_0010, 2'd2, 4'hF, 32'h55AA_55AA, 32'h0,         32'hCAFE_0000};
        vecs[4] = '{1'b0, 32'h0000_0001, 2'd0, 4'h0, 32'h0,          32'h0000_EE00, 32'h0000_EE00};

        // Reset state.
        cyc(); cyc();
        chk("rst_ctrl", {60'd0, data_ok, cache_miss, rd_req, wr_req}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_addrs", {rd_addr, wr_addr}, 64'd0);
        chk("rst_wfields", {24'd0, wr_wstrb, rd_size, wr_size, wr_data}, 64'd0);
        chk("rst_state", {61'd0, dbg_state}, 64'd0);
        rst = 1'b1;
        cyc();

        // Table of zero-wait transactions.
        for (int i = 0; i < 5; i++) do_txn(vecs[i]);

        // Store with wr_rdy held off for 3 cycles: wr_req stays up 4 cycles.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hBFD0_0003; req_size = 2'd0;
        req_wstrb = 4'b1000; req_wdata = 32'hAB00_0000;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stall_wr_req", {63'd0, wr_req}, 64'd1);
            chk("stall_wr_fields", {wr_addr, wr_data}, {32'hBFD0_0003, 32'hAB00_0000});
            chk("stall_wr_strb", {58'd0, wr_size, wr_wstrb}, {58'd0, 2'd0, 4'b1000});
            chk("stall_no_ok", {63'd0, data_ok}, 64'd0);
            wr_rdy = (i == 3);
        end
        cyc();
        wr_rdy = 1'b0;
        chk("stall_wr_drop", {63'd0, wr_req}, 64'd0);
        chk("stall_wr_wait_busy", {63'd0, cache_miss}, 64'd1);
        wr_done = 1'b1;
        pulses = 0; first_ok = -1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            wr_done = 1'b0;
            if (data_ok) begin
                pulses++;
                if (first_ok < 0) first_ok = i;
                req_valid = 1'b0;
            end
        end
        chk("stall_ok_count", pulses, 64'd1);
        chk("stall_ok_cycle", first_ok, 64'd0);
        chk("stall_rdata_kept", {32'd0, rdata}, {32'd0, 32'h0000_EE00});

        // Flush while the read request is still waiting for rd_rdy.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1FC0_0000; req_size = 2'd2;
        cyc();
        chk("fl_rdreq_up", {63'd0, rd_req}, 64'd1);
        flush = 1'b1; req_valid = 1'b0;
        cyc();
        flush = 1'b0;
        chk("fl_rdreq_drop", {61'd0, rd_req, cache_miss, data_ok}, 64'd0);
        cyc();
        chk("fl_rdreq_no_ok", {63'd0, data_ok}, 64'd0);
        v = '{1'b0, 32'h1FC0_0020, 2'd2, 4'h0, 32'h0, 32'h1111_2222, 32'h1111_2222};
        do_txn(v);

        // Flush after the read was accepted: drain the return silently.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1FC0_0040; req_size = 2'd2;
        cyc();
        rd_rdy = 1'b1;
        cyc();
        rd_rdy = 1'b0; flush = 1'b1; req_valid = 1'b0;
        cyc();
        flush = 1'b0;
        chk("drain_busy1", {62'd0, cache_miss, data_ok}, 64'b10);
        cyc();
        chk("drain_busy2", {62'd0, cache_miss, data_ok}, 64'b10);
        ret_valid = 1'b1; ret_data = 32'hDEAD_BEEF;
        cyc();
        ret_valid = 1'b0;
        chk("drain_done", {62'd0, cache_miss, data_ok}, 64'd0);
        chk("drain_rdata_kept", {32'd0, rdata}, {32'd0, 32'h1111_2222});
        chk("drain_idle", {61'd0, dbg_state}, 64'd0);

        // req_valid held through busy with a changing address.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0100; req_size = 2'd2;
        pulses = 0;
        for (int n = 1; n <= 10; n++) begin
            cyc();
            if (rd_req) chk("held_rd_addr", {32'd0, rd_addr}, 64'h100);
            if (data_ok) begin
                pulses++;
                chk("held_rdata", {32'd0, rdata}, {32'd0, 32'h3333_4444});
                req_valid = 1'b0;
            end
            req_addr = req_addr + 32'd4;
            rd_rdy = (n == 2);
            ret_valid = (n == 3);
            ret_data = 32'h3333_4444;
        end
        ret_valid = 1'b0;
        chk("held_ok_count", pulses, 64'd1);

        // Reset while waiting for wr_done.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0200; req_size = 2'd2;
        req_wstrb = 4'hF; req_wdata = 32'h0F0F_0F0F;
        cyc();
        wr_rdy = 1'b1;
        cyc();
        wr_rdy = 1'b0;
        chk("rstw_busy", {63'd0, cache_miss}, 64'd1);
        rst = 1'b0; req_valid = 1'b0;
        cyc();
        rst = 1'b1;
        chk("rstw_ctrl", {60'd0, data_ok, cache_miss, rd_req, wr_req}, 64'd0);
        chk("rstw_rdata", {32'd0, rdata}, 64'd0);
        chk("rstw_addrs", {rd_addr, wr_addr}, 64'd0);
        chk("rstw_wfields", {24'd0, wr_wstrb, rd_size, wr_size, wr_data}, 64'd0);
        chk("rstw_state", {61'd0, dbg_state}, 64'd0);

        // A late wr_done in IDLE is ignored.
        wr_done = 1'b1;
        cyc();
        wr_done = 1'b0;
        chk("late_done_ignored", {62'd0, cache_miss, data_ok}, 64'd0);
        cyc();
        chk("late_done_idle", {61'd0, dbg_state}, 64'd0);

        v = '{1'b0, 32'h0000_0300, 2'd2, 4'h0, 32'h0, 32'h7777_8888, 32'h7777_8888};
        do_txn(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
